// File: rtl/ifft_pkg.sv
// Shared types and elaboration-time helpers for the streaming IFFT.
// Twiddles are built from a Taylor series so the ROM needs no real-valued math at run time.
package ifft_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, PRIME, UNLOAD} ifft_state_t;

  localparam real PI = 3.14159265358979323846;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int bitrev(input int idx, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++)
      if (idx[i]) r = r | (1 << (bits - 1 - i));
    return r;
  endfunction

  // Angle is folded into [-pi, pi] so the series converges quickly.
  function automatic real wrap_angle(input int k, input int n);
    real a;
    a = 2.0 * PI * k / n;
    if (a > PI) a = a - 2.0 * PI;
    return a;
  endfunction

  function automatic real cos_series(input real x);
    real t, s;
    t = 1.0;
    s = 1.0;
    for (int i = 1; i <= 24; i++) begin
      t = -t * x * x / ((2.0 * i - 1.0) * (2.0 * i));
      s = s + t;
    end
    return s;
  endfunction

  function automatic real sin_series(input real x);
    real t, s;
    t = x;
    s = x;
    for (int i = 1; i <= 24; i++) begin
      t = -t * x * x / ((2.0 * i) * (2.0 * i + 1.0));
      s = s + t;
    end
    return s;
  endfunction

  function automatic int round_q(input real v, input int tw_w);
    real sc;
    sc = v * $itor((1 << (tw_w - 1)) - 1);
    if (sc >= 0.0) return $rtoi(sc + 0.5);
    else return -$rtoi(0.5 - sc);
  endfunction

  function automatic int tw_real(input int k, input int n, input int tw_w);
    return round_q(cos_series(wrap_angle(k, n)), tw_w);
  endfunction

  function automatic int tw_imag(input int k, input int n, input int tw_w);
    return round_q(sin_series(wrap_angle(k, n)), tw_w);
  endfunction

endpackage

// File: rtl/ifft_stream_if.sv
// Sample-in / sample-out streaming bundle for the IFFT.
// master drives samples and out_ready; slave is the transform block.
interface ifft_stream_if #(parameter int DATA_W = 16);
  logic signed [DATA_W-1:0] x_real;
  logic signed [DATA_W-1:0] x_imag;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] y_real;
  logic signed [DATA_W-1:0] y_imag;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output x_real, x_imag, in_valid, out_ready,
    input  in_ready, y_real, y_imag, out_valid, out_last
  );

  modport slave (
    input  x_real, x_imag, in_valid, out_ready,
    output in_ready, y_real, y_imag, out_valid, out_last
  );
endinterface

// File: rtl/ifft_butterfly.sv
// Scaled radix-2 butterfly: A=(a+b*W)>>>1, B=(a-b*W)>>>1, saturated to DATA_W.
// Purely combinational; no latency, no flow control.
module ifft_butterfly #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic signed [DATA_W-1:0] ya_re,
  output logic signed [DATA_W-1:0] ya_im,
  output logic signed [DATA_W-1:0] yb_re,
  output logic signed [DATA_W-1:0] yb_im
);
  localparam int PW = DATA_W + TW_W + 1;
  localparam int SW = DATA_W + 2;
  localparam logic signed [PW-1:0] RND  = PW'(1 << (TW_W - 2));
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(1 << (DATA_W - 1)));

  logic signed [PW-1:0] p_re, p_im;
  logic signed [SW-1:0] t_re, t_im;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] sh;
    sh = v >>> 1;
    if (sh > MAXV)      return DATA_W'(MAXV);
    else if (sh < MINV) return DATA_W'(MINV);
    else                return DATA_W'(sh);
  endfunction

  // Round-half-up of the Q(TW_W-1) product before dropping the fraction.
  assign p_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im) + RND;
  assign p_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re) + RND;
  assign t_re = SW'(p_re >>> (TW_W - 1));
  assign t_im = SW'(p_im >>> (TW_W - 1));

  assign ya_re = sat(SW'(a_re) + t_re);
  assign ya_im = sat(SW'(a_im) + t_im);
  assign yb_re = sat(SW'(a_re) - t_re);
  assign yb_im = sat(SW'(a_im) - t_im);
endmodule

// File: rtl/ifft_stream.sv
// In-place radix-2 DIT inverse FFT, one shared butterfly, natural-order output.
// Latency: last input edge to first out_valid is (N/2)*log2(N)+2 cycles.
// Backpressure: out_ready stalls UNLOAD with y held; in_ready low outside LOAD.
module ifft_stream
  import ifft_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  ifft_stream_if.slave io,
  output logic         busy
);
  localparam int LW = clog2(N);
  localparam logic [LW-1:0] LAST_IDX   = LW'(N - 1);
  localparam logic [LW-1:0] LAST_PAIR  = LW'(N / 2 - 1);
  localparam logic [LW-1:0] LAST_STAGE = LW'(LW - 1);

  typedef logic signed [DATA_W-1:0] smp_t;
  typedef logic signed [TW_W-1:0]   tw_t;

  ifft_state_t state_q, state_d;
  logic [LW-1:0] cnt_q, stage_q, pair_q, n_q;
  logic [LW-1:0] half, j, addr_a, addr_b, tw_idx, wr_addr;
  logic          accept, last_bf;
  smp_t          mem_re [N];
  smp_t          mem_im [N];
  tw_t           rom_re [N];
  tw_t           rom_im [N];
  smp_t          ya_re, ya_im, yb_re, yb_im;
  smp_t          y_re_q, y_im_q;
  logic          last_q;

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam int RE = tw_real(g, N, TW_W);
    localparam int IM = tw_imag(g, N, TW_W);
    assign rom_re[g] = TW_W'(RE);
    assign rom_im[g] = TW_W'(IM);
  end

  // Pair p in stage s: insert a zero at bit s to get a, set it to get b.
  always_comb begin
    half    = LW'(1) << stage_q;
    j       = pair_q & (half - LW'(1));
    addr_a  = ((pair_q >> stage_q) << (stage_q + LW'(1))) | j;
    addr_b  = addr_a | half;
    tw_idx  = j << (LAST_STAGE - stage_q);
    wr_addr = LW'(bitrev(int'(cnt_q), LW));
  end

  assign accept  = io.in_valid && (state_q == LOAD);
  assign last_bf = (stage_q == LAST_STAGE) && (pair_q == LAST_PAIR);
  assign busy    = (state_q != LOAD);

  always_comb begin
    state_d      = state_q;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        io.in_ready = 1'b1;
        if (accept && cnt_q == LAST_IDX) state_d = COMPUTE;
      end
      COMPUTE: if (last_bf) state_d = PRIME;
      PRIME:   state_d = UNLOAD;
      UNLOAD: begin
        io.out_valid = 1'b1;
        if (io.out_ready && n_q == LAST_IDX) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  ifft_butterfly #(.DATA_W(DATA_W), .TW_W(TW_W)) u_bf (
    .a_re  (mem_re[addr_a]),
    .a_im  (mem_im[addr_a]),
    .b_re  (mem_re[addr_b]),
    .b_im  (mem_im[addr_b]),
    .w_re  (rom_re[tw_idx]),
    .w_im  (rom_im[tw_idx]),
    .ya_re (ya_re),
    .ya_im (ya_im),
    .yb_re (yb_re),
    .yb_im (yb_im)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_re[wr_addr] <= io.x_real;
      mem_im[wr_addr] <= io.x_imag;
    end else if (state_q == COMPUTE) begin
      mem_re[addr_a] <= ya_re;
      mem_im[addr_a] <= ya_im;
      mem_re[addr_b] <= yb_re;
      mem_im[addr_b] <= yb_im;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      pair_q  <= '0;
      n_q     <= '0;
      y_re_q  <= '0;
      y_im_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: if (accept) cnt_q <= cnt_q + LW'(1);
        COMPUTE: begin
          if (pair_q == LAST_PAIR) begin
            pair_q  <= '0;
            stage_q <= last_bf ? '0 : stage_q + LW'(1);
          end else begin
            pair_q <= pair_q + LW'(1);
          end
        end
        PRIME: begin
          y_re_q <= mem_re[0];
          y_im_q <= mem_im[0];
          last_q <= 1'b0;
          n_q    <= '0;
        end
        UNLOAD: begin
          if (io.out_ready) begin
            if (n_q == LAST_IDX) begin
              n_q    <= '0;
              last_q <= 1'b0;
            end else begin
              n_q    <= n_q + LW'(1);
              y_re_q <= mem_re[n_q + LW'(1)];
              y_im_q <= mem_im[n_q + LW'(1)];
              last_q <= (n_q + LW'(1)) == LAST_IDX;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io.y_real   = y_re_q;
  assign io.y_imag   = y_im_q;
  assign io.out_last = last_q;
endmodule

// File: tb/tb_ifft_stream.sv
// Directed-vector bench for ifft_stream (N=8): expected outputs are queued per frame
// and a free-running monitor pops and compares them on each output handshake.
module tb_ifft_stream;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int S  = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  ifft_stream_if #(.DATA_W(DW)) io ();

  ifft_stream #(.N(N), .DATA_W(DW), .TW_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int tol;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   c_last = 0;
  bit   lat_en = 1'b0;
  bit   lat_seen = 1'b0;
  bit   rand_rdy = 1'b0;
  int   xr[N], xi[N], er[N], ei[N], et[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  task automatic clear_tables();
    for (int k = 0; k < N; k++) begin
      xr[k] = 0; xi[k] = 0; er[k] = 0; ei[k] = 0; et[k] = 2;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.re = er[k]; e.im = ei[k]; e.tol = et[k]; e.last = (k == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_frame();
    int  guard;
    bit  ok;
    for (int k = 0; k < N; k++) begin
      io.x_real   = DW'(xr[k]);
      io.x_imag   = DW'(xi[k]);
      io.in_valid = 1'b1;
      guard = 0;
      forever begin
        @(negedge clk);
        ok = io.in_ready;
        if (ok && k == N - 1) c_last = cyc;
        @(posedge clk);
        #1;
        if (ok) break;
        guard++;
        if (guard > 300) begin
          checks++; errors++;
          $display("FAIL in_ready_timeout: in_ready stayed 0 for sample %0d, need 1", k);
          io.in_valid = 1'b0;
          return;
        end
      end
    end
    io.in_valid = 1'b0;
    io.x_real   = '0;
    io.x_imag   = '0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 1000) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: %0d outputs still pending, need 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : ready_drv
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      io.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    exp_t e;
    bit   prev_stall;
    int   prev_re, prev_im, prev_last;
    prev_stall = 1'b0;
    prev_re = 0; prev_im = 0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_re", int'(io.y_real), prev_re, 0);
        chk("hold_im", int'(io.y_imag), prev_im, 0);
        chk("hold_last", int'(io.out_last), prev_last, 0);
      end
      if (io.out_valid) begin
        chk("in_ready_during_unload", int'(io.in_ready), 0, 0);
        if (lat_en && !lat_seen) begin
          lat_seen = 1'b1;
          chk("first_out_latency", cyc - c_last, S + 2, 0);
        end
        if (io.out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got (%0d,%0d) with none expected",
                     io.y_real, io.y_imag);
          end else begin
            e = sb.pop_front();
            chk("y_real", int'(io.y_real), e.re, e.tol);
            chk("y_imag", int'(io.y_imag), e.im, e.tol);
            chk("out_last", int'(io.out_last), int'(e.last), 0);
          end
        end
      end
      prev_stall = io.out_valid && !io.out_ready;
      prev_re    = int'(io.y_real);
      prev_im    = int'(io.y_imag);
      prev_last  = int'(io.out_last);
    end
  end

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    io.in_valid = 1'b0;
    io.x_real   = '0;
    io.x_imag   = '0;
    reset_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(io.in_ready), 1, 0);
    chk("rst_out_valid", int'(io.out_valid), 0, 0);
    chk("rst_out_last", int'(io.out_last), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_y_real", int'(io.y_real), 0, 0);
    chk("rst_y_imag", int'(io.y_imag), 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Impulse at k=0: flat 1000 everywhere, also times the first output.
    clear_tables();
    xr[0] = 8000;
    for (int k = 0; k < N; k++) begin er[k] = 1000; et[k] = 1; end
    lat_en = 1'b1;
    push_expected();
    send_frame();
    wait_drain("impulse0");
    chk("latency_observed", int'(lat_seen), 1, 0);
    lat_en = 1'b0;

    // Constant input: all energy lands in bin 0.
    clear_tables();
    for (int k = 0; k < N; k++) xr[k] = 800;
    er[0] = 800; et[0] = 1;
    push_expected();
    send_frame();
    wait_drain("dc");

    // Impulse at k=1: unit-circle rotation by pi/4 per output.
    clear_tables();
    xr[1] = 8000;
    er = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    ei = '{0, 707, 1000, 707, 0, -707, -1000, -707};
    push_expected();
    send_frame();
    wait_drain("impulse1");

    // Same frame under random backpressure.
    rand_rdy = 1'b1;
    push_expected();
    send_frame();
    wait_drain("backpressure");
    rand_rdy = 1'b0;

    // Full-scale input must not wrap.
    clear_tables();
    for (int k = 0; k < N; k++) begin xr[k] = 32767; xi[k] = 32767; end
    er[0] = 32767; ei[0] = 32767; et[0] = N;
    push_expected();
    send_frame();
    wait_drain("fullscale");

    // Abort a frame mid-COMPUTE with reset.
    clear_tables();
    xr[0] = 8000;
    send_frame();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_in_compute", int'(busy), 1, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", int'(io.out_valid), 0, 0);
    chk("abort_in_ready", int'(io.in_ready), 1, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_y_real", int'(io.y_real), 0, 0);
    chk("abort_y_imag", int'(io.y_imag), 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Fresh impulse at k=2 after the abort: rotation by pi/2 per output.
    clear_tables();
    xr[2] = 8000;
    er = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    ei = '{0, 1000, 0, -1000, 0, 1000, 0, -1000};
    push_expected();
    send_frame();
    wait_drain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
